// File: rtl/multi_counter_pkg.sv
// ----------------------------------------------------------------------------
// multi_counter_pkg : register offsets, control bit indices and control struct
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package multi_counter_pkg;

  localparam logic [1:0] REG_COUNT   = 2'd0;
  localparam logic [1:0] REG_COMPARE = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_UP      = 1;
  localparam int CTRL_INT_EN  = 2;
  localparam int CTRL_RELOAD  = 3;
  localparam int CTRL_ONESHOT = 4;

  // Field order makes bit 0 of the packed value the enable bit.
  typedef struct packed {
    logic oneshot;
    logic reload;
    logic int_en;
    logic up;
    logic enable;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/counter_channel.sv
// ----------------------------------------------------------------------------
// counter_channel : one counter/timer channel with compare, control and flag
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module counter_channel
  import multi_counter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_count_i,
  input  logic             wr_compare_i,
  input  logic             wr_control_i,
  input  logic             wr_status_i,
  input  logic [31:0]      wdata_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] compare_o,
  output ctrl_t            ctrl_o,
  output logic [1:0]       status_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] compare_q, compare_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             flag_q, flag_d;
  logic             w_match;
  logic             w_unused_wdata;

  assign w_unused_wdata = ^wdata_i;

  assign w_match = ctrl_q.enable &
                   (ctrl_q.up ? (count_q == compare_q) : (count_q == '0));

  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    ctrl_d    = ctrl_q;
    flag_d    = flag_q;

    if (ctrl_q.enable) begin
      if (w_match && ctrl_q.oneshot) begin
        ctrl_d.enable = 1'b0;
      end else if (w_match && ctrl_q.reload) begin
        count_d = ctrl_q.up ? '0 : compare_q;
      end else begin
        count_d = ctrl_q.up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end
    end

    // Bus writes are applied last so they override the counting logic.
    if (wr_count_i)   count_d   = wdata_i[WIDTH-1:0];
    if (wr_compare_i) compare_d = wdata_i[WIDTH-1:0];
    if (wr_control_i) begin
      ctrl_d.enable  = wdata_i[CTRL_ENABLE];
      ctrl_d.up      = wdata_i[CTRL_UP];
      ctrl_d.int_en  = wdata_i[CTRL_INT_EN];
      ctrl_d.reload  = wdata_i[CTRL_RELOAD];
      ctrl_d.oneshot = wdata_i[CTRL_ONESHOT];
    end

    if (wr_status_i && wdata_i[0]) flag_d = 1'b0;
    if (w_match)                   flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      compare_q <= '0;
      ctrl_q    <= '0;
      flag_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ctrl_q    <= ctrl_d;
      flag_q    <= flag_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ctrl_o    = ctrl_q;
  assign status_o  = {(count_q < compare_q), flag_q};
  assign irq_o     = flag_q & ctrl_q.int_en;

endmodule

`default_nettype wire

// File: rtl/multi_counter_peripheral.sv
// ----------------------------------------------------------------------------
// multi_counter_peripheral : CHANNELS counter/timers on an Avalon-style bus
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module multi_counter_peripheral
  import multi_counter_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = $clog2(CHANNELS*4)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic              read_valid,
  output logic [31:0]       data_out,
  output logic              irq
);

  logic [31:0]         w_chan;
  logic [1:0]          w_reg;
  logic [31:0]         w_rdata;
  logic [WIDTH-1:0]    w_count   [CHANNELS];
  logic [WIDTH-1:0]    w_compare [CHANNELS];
  ctrl_t               w_ctrl    [CHANNELS];
  logic [1:0]          w_status  [CHANNELS];
  logic [CHANNELS-1:0] w_irq;

  logic [31:0] data_q;
  logic        valid_q;

  // Channel index compared as a full word so unmapped channels decode to nothing.
  assign w_chan = 32'(address) >> 2;
  assign w_reg  = address[1:0];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic w_sel;
    assign w_sel = write && (w_chan == 32'(g));

    counter_channel #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk          (clk),
      .rst_n        (reset),
      .wr_count_i   (w_sel && (w_reg == REG_COUNT)),
      .wr_compare_i (w_sel && (w_reg == REG_COMPARE)),
      .wr_control_i (w_sel && (w_reg == REG_CONTROL)),
      .wr_status_i  (w_sel && (w_reg == REG_STATUS)),
      .wdata_i      (data_in),
      .count_o      (w_count[g]),
      .compare_o    (w_compare[g]),
      .ctrl_o       (w_ctrl[g]),
      .status_o     (w_status[g]),
      .irq_o        (w_irq[g])
    );
  end

  always_comb begin
    w_rdata = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_chan == 32'(c)) begin
        case (w_reg)
          REG_COUNT:   w_rdata = 32'(w_count[c]);
          REG_COMPARE: w_rdata = 32'(w_compare[c]);
          REG_CONTROL: w_rdata = 32'(w_ctrl[c]);
          REG_STATUS:  w_rdata = 32'(w_status[c]);
          default:     w_rdata = '0;
        endcase
      end
    end
  end

  // Read data is captured from pre-edge state, so a same-cycle write is not visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= read;
      if (read) data_q <= w_rdata;
    end
  end

  assign read_valid = valid_q;
  assign data_out   = data_q;
  assign irq        = |w_irq;

endmodule

`default_nettype wire

// File: tb/tb_multi_counter_peripheral.sv
// ----------------------------------------------------------------------------
// tb_multi_counter_peripheral : scoreboard bench, CHANNELS=3, WIDTH=8
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_multi_counter_peripheral;

  logic        clk = 1'b0;
  logic        reset;
  logic        read;
  logic        write;
  logic [3:0]  address;
  logic [31:0] data_in;
  logic        read_valid;
  logic [31:0] data_out;
  logic        irq;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q [$];
  logic        rd_pend = 1'b0;

  multi_counter_peripheral #(
    .CHANNELS (3),
    .WIDTH    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .read       (read),
    .write      (write),
    .address    (address),
    .data_in    (data_in),
    .read_valid (read_valid),
    .data_out   (data_out),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one result exactly one edge after each read strobe.
  always @(posedge clk) rd_pend <= read;

  always @(negedge clk) begin
    if (rd_pend || read_valid) check("read_latency", 32'(read_valid), 32'(rd_pend));
    if (read_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read", data_out, 32'hDEAD_BEEF);
      end else begin
        check("read_data", data_out, exp_q.pop_front());
      end
    end
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    write = 1'b1; address = a; data_in = d;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    read = 1'b1; address = a;
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  task automatic rdwr(input logic [3:0] a, input logic [31:0] d, input logic [31:0] e);
    exp_q.push_back(e);
    read = 1'b1; write = 1'b1; address = a; data_in = d;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; read = 1'b0; write = 1'b0; address = '0; data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Reset mid-count with irq and data_out non-zero
    wr(4'd2, 32'h05);
    idle(1);
    rd(4'd0, 32'hFF);
    check("pre_reset_irq", 32'(irq), 32'd1);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_data_out", data_out, 32'd0);
    check("rst_read_valid", 32'(read_valid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 12; a++) rd(4'(a), 32'd0);
    check("post_rst_irq", 32'(irq), 32'd0);

    // Up auto-reload on ch0
    wr(4'd1, 32'd3);
    wr(4'd2, 32'h0F);
    rd(4'd0, 32'd0); rd(4'd0, 32'd1); rd(4'd0, 32'd2);
    rd(4'd0, 32'd3); rd(4'd0, 32'd0); rd(4'd0, 32'd1);
    check("reload_irq_set", 32'(irq), 32'd1);
    wr(4'd3, 32'd1);
    check("w1c_irq_clear", 32'(irq), 32'd0);
    idle(1);
    check("rematch_irq", 32'(irq), 32'd1);
    idle(3);
    wr(4'd3, 32'd1);
    check("w1c_vs_match", 32'(irq), 32'd1);
    rd(4'd3, 32'd3);
    wr(4'd2, 32'd0);
    wr(4'd3, 32'd1);

    // Down one-shot on ch1
    wr(4'd4, 32'd2);
    wr(4'd6, 32'h11);
    rd(4'd4, 32'd2); rd(4'd4, 32'd1); rd(4'd4, 32'd0);
    rd(4'd4, 32'd0); rd(4'd4, 32'd0);
    rd(4'd6, 32'h10);
    rd(4'd7, 32'd1);
    check("oneshot_irq", 32'(irq), 32'd0);

    // Free-run wrap up then down on ch2
    wr(4'd9, 32'h10);
    wr(4'd8, 32'hFE);
    wr(4'd10, 32'h03);
    rd(4'd8, 32'hFE); rd(4'd8, 32'hFF); rd(4'd8, 32'h00); rd(4'd8, 32'h01);
    wr(4'd10, 32'd0);
    rd(4'd11, 32'd2);
    wr(4'd8, 32'h01);
    wr(4'd10, 32'h05);
    rd(4'd8, 32'h01); rd(4'd8, 32'h00); rd(4'd8, 32'hFF);
    check("down_match_irq", 32'(irq), 32'd1);
    rd(4'd11, 32'd1);
    wr(4'd10, 32'd0);
    check("irq_int_en_off", 32'(irq), 32'd0);

    // Count write collides with a count step
    wr(4'd0, 32'd10);
    wr(4'd2, 32'h03);
    idle(1);
    wr(4'd0, 32'd100);
    rd(4'd0, 32'd100);
    rd(4'd0, 32'd101);
    wr(4'd2, 32'd0);

    // Read and write of compare in the same cycle
    rdwr(4'd5, 32'h55, 32'd0);
    rd(4'd5, 32'h55);

    // Unmapped channel 3 and irq OR across channels
    wr(4'd13, 32'hAB);
    rd(4'd13, 32'd0);
    wr(4'd12, 32'h77);
    rd(4'd12, 32'd0);
    rd(4'd1, 32'd3);
    rd(4'd9, 32'h10);
    wr(4'd10, 32'h04);
    check("irq_or_ch2", 32'(irq), 32'd1);
    wr(4'd2, 32'h04);
    wr(4'd11, 32'd1);
    check("irq_or_clear", 32'(irq), 32'd0);

    idle(2);
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
